fetch_pc_unit: RTL

Program-counter and fetch-control stage directly upstream of the fetch instruction memory. It holds the PC that addresses instruction memory, and advances it by +4, by jump, or by branch redirect. It honours hazard stalls and debug single-step gating. When the fetched word equals the HALT encoding, it stops fetch and signals the debug unit.

---
 rtl/fetch_pc_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch control ahead of instruction memory.
// The PC advances by +4 (wrapped), by jump, or by branch, and it stops on a HALT word.
module fetch_pc_unit #(
   parameter int              NB        = 32,
   parameter int              TAM       = 256,
   parameter logic [NB-1:0]   RESET_PC  = '0,
   parameter logic [NB-1:0]   HALT_WORD = {NB{1'b1}}
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_step,
   input  logic            i_stall,
   input  logic            i_jump,
   input  logic [NB-1:0]   i_jump_target,
   input  logic            i_branch_taken,
   input  logic [NB-1:0]   i_branch_target,
   input  logic [NB-1:0]   i_instruction,
   output logic [NB-1:0]   o_pc,
   output logic [NB-1:0]   o_pc_plus_4,
   output logic            o_halted,
   output logic [NB-1:0]   o_cycle_count
);

   localparam logic [NB-1:0] PC_SPAN  = NB'(4 * TAM);
   localparam logic [NB-1:0] CNT_MAX  = {NB{1'b1}};

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t          state_r;
   logic [NB-1:0]   pc_r;
   logic [NB-1:0]   count_r;
   logic            halted_r;
   logic [NB-1:0]   pc_plus_4_s;

   // Sequential successor wraps inside the instruction memory window.
   always_comb begin
      pc_plus_4_s = (pc_r + NB'(4)) % PC_SPAN;
   end

   // Single-edge PC / counter / halt FSM update.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_r  <= RUN;
         pc_r     <= RESET_PC;
         count_r  <= '0;
         halted_r <= 1'b0;
      end else begin
         case (state_r)
            RUN: begin
               if (i_step) begin
                  if (count_r != CNT_MAX) begin
                     count_r <= count_r + NB'(1);
                  end else begin
                     count_r <= count_r;
                  end
                  // A redirect in the same cycle as a HALT word marks that word as wrong-path.
                  if (i_jump) begin
                     pc_r <= {i_jump_target[NB-1:2], 2'b00};
                  end else if (i_branch_taken) begin
                     pc_r <= {i_branch_target[NB-1:2], 2'b00};
                  end else if (i_stall) begin
                     pc_r <= pc_r;
                  end else if (i_instruction == HALT_WORD) begin
                     pc_r     <= pc_r;
                     state_r  <= HALTED;
                     halted_r <= 1'b1;
                  end else begin
                     pc_r <= pc_plus_4_s;
                  end
               end else begin
                  pc_r    <= pc_r;
                  count_r <= count_r;
               end
            end
            HALTED: begin
               pc_r     <= pc_r;
               count_r  <= count_r;
               halted_r <= 1'b1;
            end
            default: begin
               state_r  <= RUN;
               pc_r     <= RESET_PC;
               count_r  <= '0;
               halted_r <= 1'b0;
            end
         endcase
      end
   end

   assign o_pc          = pc_r;
   assign o_pc_plus_4   = pc_plus_4_s;
   assign o_halted      = halted_r;
   assign o_cycle_count = count_r;

endmodule
